// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory access stage.
// Used by mem_access_unit and mem_lane_align.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  // Size 11 is never legal; half and word accesses must be naturally aligned.
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size_e'(size))
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables and replication,
// plus load lane extraction with zero/sign extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = st_data;
    case (size_e'(st_size))
      SZ_BYTE: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be    = 4'b0011 << st_addr_lo;
        st_wdata = {2{st_data[15:0]}};
      end
      SZ_WORD: begin
        st_be    = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = st_data;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0 before extending.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_data    = ld_rdata;
    case (size_e'(ld_size))
      SZ_BYTE: ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage after the ALU: issues req/ack memory accesses with a
// wait-timeout and produces one registered writeback beat per operation.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [1:0]        ex_size,
  input  logic              ex_signed,
  input  logic              ex_rd_we,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [31:0]       wb_data,
  output logic              wb_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             lat_load;
  logic             lat_rd_we;
  logic [1:0]       lat_size;
  logic             lat_signed;
  logic [1:0]       lat_addr_lo;

  logic             is_mem;
  logic             illegal;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign ex_ready = (state == ST_IDLE) && !rst;
  assign is_mem   = ex_mem_read | ex_mem_write;
  assign illegal  = access_illegal(ex_size, ex_alu_result[1:0]);

  mem_lane_align u_align (
    .st_size    (ex_size),
    .st_addr_lo (ex_alu_result[1:0]),
    .st_data    (ex_store_data),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_size    (lat_size),
    .ld_signed  (lat_signed),
    .ld_addr_lo (lat_addr_lo),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  // Ack has priority over the timeout limit; late acks in IDLE fall through unused.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= 4'b0000;
      mem_wdata   <= '0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_data     <= '0;
      wb_err      <= 1'b0;
      lat_load    <= 1'b0;
      lat_rd_we   <= 1'b0;
      lat_size    <= 2'b00;
      lat_signed  <= 1'b0;
      lat_addr_lo <= 2'b00;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_data  <= ex_alu_result;
              wb_we    <= ex_rd_we;
              wb_err   <= 1'b0;
            end else if (illegal) begin
              wb_valid <= 1'b1;
              wb_data  <= '0;
              wb_we    <= 1'b0;
              wb_err   <= 1'b1;
            end else begin
              state       <= ST_ACCESS;
              wait_cnt    <= '0;
              mem_req     <= 1'b1;
              mem_we      <= ex_mem_write & ~ex_mem_read;
              mem_addr    <= {ex_alu_result[ADDR_W-1:2], 2'b00};
              mem_be      <= st_be;
              mem_wdata   <= st_wdata;
              lat_load    <= ex_mem_read;
              lat_rd_we   <= ex_rd_we;
              lat_size    <= ex_size;
              lat_signed  <= ex_signed;
              lat_addr_lo <= ex_alu_result[1:0];
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b0;
            wb_data  <= lat_load ? ld_data : 32'h0;
            wb_we    <= lat_load ? lat_rd_we : 1'b0;
          end else if (wait_cnt == CNT_LIMIT) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_we    <= 1'b0;
            wb_data  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected writeback beats are queued
// as operations are driven and compared by a monitor when wb_valid pulses.
module tb_mem_access_unit;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
    logic        err;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_signed;
  logic        ex_rd_we;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [31:0] wb_data;
  logic        wb_err;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_size       (ex_size),
    .ex_signed     (ex_signed),
    .ex_rd_we      (ex_rd_we),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .wb_valid      (wb_valid),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .wb_err        (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every writeback beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got we=%b data=%h err=%b, required no beat", wb_we, wb_data, wb_err);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if ({wb_we, wb_data, wb_err} !== {e.we, e.data, e.err}) begin
          errors++;
          $display("[TB] FAIL wb_beat: got we=%b data=%h err=%b, required we=%b data=%h err=%b",
                   wb_we, wb_data, wb_err, e.we, e.data, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid      = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_size       = 2'b00;
    ex_signed     = 1'b0;
    ex_rd_we      = 1'b0;
    ex_alu_result = 32'h0;
    ex_store_data = 32'h0;
  endtask

  task automatic test_reset();
    clear_ex();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    rst       = 1'b1;
    tick();
    tick();
    checks++;
    if (ex_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, required 0", ex_ready);
    end
    checks++;
    if ({mem_req, mem_we, wb_valid, wb_we, wb_err, mem_be, mem_addr, mem_wdata, wb_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got req=%b we=%b wbv=%b wbwe=%b err=%b be=%b addr=%h wdata=%h wbdata=%h, required all 0",
               mem_req, mem_we, wb_valid, wb_we, wb_err, mem_be, mem_addr, mem_wdata, wb_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b, required 1", ex_ready);
    end
  endtask

  task automatic test_passthrough();
    ex_valid = 1'b1;
    ex_alu_result = 32'h0000_1234;
    ex_rd_we = 1'b1;
    sb.push_back('{we: 1'b1, data: 32'h0000_1234, err: 1'b0});
    tick();
    ex_alu_result = 32'h0000_0005;
    ex_rd_we = 1'b0;
    sb.push_back('{we: 1'b0, data: 32'h0000_0005, err: 1'b0});
    checks++;
    if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL passthrough_ready_req: got ready=%b req=%b, required ready=1 req=0", ex_ready, mem_req);
    end
    tick();
    clear_ex();
    checks++;
    if (ex_ready !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL passthrough_second: got ready=%b req=%b, required ready=1 req=0", ex_ready, mem_req);
    end
    tick();
  endtask

  task automatic test_byte_load(input logic sgn, input logic [31:0] expected);
    ex_valid = 1'b1;
    ex_mem_read = 1'b1;
    ex_size = 2'b00;
    ex_signed = sgn;
    ex_rd_we = 1'b1;
    ex_alu_result = 32'h0000_0103;
    sb.push_back('{we: 1'b1, data: expected, err: 1'b0});
    tick();
    // Scramble upstream fields to show they were latched at accept.
    ex_valid = 1'b0;
    ex_signed = ~sgn;
    ex_size = 2'b10;
    ex_rd_we = 1'b0;
    ex_alu_result = 32'hFFFF_FFFF;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, ex_ready} !== {1'b1, 1'b0, 32'h0000_0100, 4'b1000, 1'b0}) begin
      errors++;
      $display("[TB] FAIL byte_load_req: got req=%b we=%b addr=%h be=%b ready=%b, required req=1 we=0 addr=00000100 be=1000 ready=0",
               mem_req, mem_we, mem_addr, mem_be, ex_ready);
    end
    tick();
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h80FF_0000;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checks++;
    if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL byte_load_done: got req=%b ready=%b, required req=0 ready=1", mem_req, ex_ready);
    end
    clear_ex();
    tick();
  endtask

  task automatic test_half_store();
    ex_valid = 1'b1;
    ex_mem_write = 1'b1;
    ex_size = 2'b01;
    ex_rd_we = 1'b1;
    ex_alu_result = 32'h0000_0022;
    ex_store_data = 32'hABCD_1234;
    sb.push_back('{we: 1'b0, data: 32'h0, err: 1'b0});
    tick();
    clear_ex();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 32'h0000_0020, 4'b1100, 32'h1234_1234}) begin
      errors++;
      $display("[TB] FAIL half_store_req: got req=%b we=%b addr=%h be=%b wdata=%h, required req=1 we=1 addr=00000020 be=1100 wdata=12341234",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL half_store_done: got req=%b, required 0", mem_req);
    end
    tick();
  endtask

  task automatic test_misaligned();
    ex_valid = 1'b1;
    ex_mem_read = 1'b1;
    ex_size = 2'b10;
    ex_rd_we = 1'b1;
    ex_alu_result = 32'h0000_0006;
    sb.push_back('{we: 1'b0, data: 32'h0, err: 1'b1});
    tick();
    // Illegal size 11 store right behind it, at an aligned address.
    ex_mem_read = 1'b0;
    ex_mem_write = 1'b1;
    ex_size = 2'b11;
    ex_alu_result = 32'h0000_0008;
    sb.push_back('{we: 1'b0, data: 32'h0, err: 1'b1});
    checks++;
    if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misaligned_noreq: got req=%b ready=%b, required req=0 ready=1", mem_req, ex_ready);
    end
    tick();
    clear_ex();
    checks++;
    if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL illegal_size_noreq: got req=%b ready=%b, required req=0 ready=1", mem_req, ex_ready);
    end
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles;
    ex_valid = 1'b1;
    ex_mem_read = 1'b1;
    ex_size = 2'b10;
    ex_rd_we = 1'b1;
    ex_alu_result = 32'h0000_0040;
    sb.push_back('{we: 1'b0, data: 32'h0, err: 1'b1});
    tick();
    clear_ex();
    req_cycles = 0;
    while (mem_req === 1'b1 && req_cycles < 20) begin
      req_cycles++;
      tick();
    end
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("[TB] FAIL timeout_req_cycles: got %0d, required 4", req_cycles);
    end
    tick();
    // Ack on the last allowed cycle must win over the timeout.
    ex_valid = 1'b1;
    ex_mem_read = 1'b1;
    ex_size = 2'b10;
    ex_rd_we = 1'b1;
    ex_alu_result = 32'h0000_0044;
    sb.push_back('{we: 1'b1, data: 32'h1357_2468, err: 1'b0});
    tick();
    clear_ex();
    tick();
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_4th_cycle_req: got %b, required 1", mem_req);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'h1357_2468;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL limit_ack_done: got req=%b, required 0", mem_req);
    end
    tick();
  endtask

  task automatic test_reset_in_access();
    ex_valid = 1'b1;
    ex_mem_read = 1'b1;
    ex_size = 2'b10;
    ex_rd_we = 1'b1;
    ex_alu_result = 32'h0000_0010;
    tick();
    clear_ex();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_drops_req: got %b, required 0", mem_req);
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    checks++;
    if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL late_ack_ignored: got req=%b ready=%b, required req=0 ready=1", mem_req, ex_ready);
    end
    ex_valid = 1'b1;
    ex_alu_result = 32'h0000_0077;
    ex_rd_we = 1'b1;
    sb.push_back('{we: 1'b1, data: 32'h0000_0077, err: 1'b0});
    tick();
    clear_ex();
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_byte_load(1'b1, 32'hFFFF_FF80);
    test_byte_load(1'b0, 32'h0000_0080);
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_in_access();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_beats: got %0d outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory stage directly downstream of the ALU. It consumes the ALU result as a load/store address or as a pass-through value, and drives a single-port data memory through a req/ack handshake with variable latency. It byte-aligns and sign-extends load data, and presents one registered writeback beat per accepted operation. A wait-timeout flags memory that never responds.

Parameters:
- ADDR_W, 32, width of the address taken from the ALU result.
- TIMEOUT_CYCLES, 16, maximum cycles mem_req may stay high without mem_ack (≥2).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  upstream operation valid.
- ex_ready  out  1  unit can accept an operation this cycle.
- ex_mem_read  in  1  operation is a load.
- ex_mem_write  in  1  operation is a store (mem_read and mem_write both set → treated as load).
- ex_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- ex_signed  in  1  sign-extend loads.
- ex_rd_we  in  1  operation writes a register.
- ex_alu_result  in  32  address or pass-through value.
- ex_store_data  in  32  store source, right-aligned.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0).
- mem_be  out  4  byte enables, little-endian.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  one-cycle completion; rdata valid the same cycle.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle writeback beat.
- wb_we  out  1  register write enable for this beat.
- wb_data  out  32  result to register file.
- wb_err  out  1  misaligned, illegal size, or timeout.

Behaviour:
- Reset: state IDLE; mem_req, mem_we, wb_valid, wb_we, wb_err = 0; mem_addr, mem_be, mem_wdata, wb_data = 0; timeout counter = 0.
- FSM states: IDLE and ACCESS. ex_ready = (state==IDLE) and not rst. Accept = ex_valid & ex_ready.
- No back-pressure from writeback. wb_valid is a 1-cycle pulse. All other wb_* outputs hold their value until the next beat.
- Non-memory accept at cycle N: at N+1, wb_valid=1, wb_data=ex_alu_result, wb_we=ex_rd_we, wb_err=0. State stays IDLE, so back-to-back accepts give 1 op/cycle.
- Alignment rules: half needs addr[0]=0; word needs addr[1:0]=0; size 11 is always illegal.
- Memory accept with a violation: no request is issued. At N+1, wb_valid=1, wb_err=1, wb_we=0, wb_data=0.
- Legal memory accept at N:
  - At N+1, state=ACCESS and mem_req=1, with mem_addr, mem_we, mem_be, mem_wdata registered.
  - mem_be: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'b1111. Loads also drive mem_be to the same pattern.
  - mem_wdata: byte replicated ×4; half replicated ×2; word unchanged.
- ACCESS:
  - The counter increments each cycle mem_req=1 and mem_ack=0.
  - On mem_ack at cycle M: mem_req drops at M+1, state returns to IDLE at M+1, and wb_valid=1 at M+1.
    - Load: wb_data = selected lane of mem_rdata, zero- or sign-extended; wb_we=ex_rd_we.
    - Store: wb_data=0; wb_we=0.
  - Earliest ack is N+1, so load-to-writeback is ≥2 cycles.
- Timeout: if the counter reaches TIMEOUT_CYCLES-1 with no ack, then next cycle mem_req=0, state=IDLE, and wb_valid=1 with wb_err=1, wb_we=0. If ack arrives in the same cycle as the limit, the ack wins and the beat is normal.
- mem_ack while IDLE is ignored, including late acks after reset or timeout.
- Reset during ACCESS: mem_req=0 at the next edge; the operation is discarded and no wb_valid is issued.
- ex_* inputs needed for writeback (rd_we, size, signed, addr[1:0]) are latched at accept; upstream may change them afterwards.

Decomposition:
- Shared package (mem_pkg):
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - state encodings ST_IDLE/ST_ACCESS;
  - default TIMEOUT constant.
- One combinational sub-module, mem_lane_align. It produces store lane replication and mem_be from (size, addr[1:0], data). It also extracts and extends load data from (size, signed, addr[1:0], rdata). The FSM and counter stay in mem_access_unit.

Test Plan:
- Pass-through: accept alu_result=0x0000_1234, rd_we=1 at N, then 0x5 at N+1 → wb beats at N+1 and N+2 with those values; ex_ready stays 1; mem_req never rises.
- Signed byte load: addr=0x103, ack at 3rd ACCESS cycle with rdata=0x80FF_0000 → mem_addr=0x100, mem_be=1000, wb_data=0xFFFF_FF80. The same with signed=0 → 0x0000_0080.
- Half store: addr=0x22, data=0xABCD_1234 → mem_we=1, mem_be=1100, mem_wdata=0x1234_1234; beat with wb_we=0, wb_err=0.
- Misaligned word load at addr=0x6 → mem_req stays 0; next cycle wb_err=1, wb_we=0; ex_ready=1 throughout.
- Timeout, TIMEOUT_CYCLES=4, no ack → mem_req high exactly 4 cycles, then wb_err=1. Rerun with ack on the 4th cycle → normal beat, wb_err=0.
- Reset asserted on the 2nd ACCESS cycle, ack one cycle later → mem_req=0 after the reset edge; no wb_valid; ack ignored; the next op is accepted normally.
